// File: rtl/axis_fifo_pkg.sv
// Shared types and constants for the single-clock AXI-Stream packet FIFO.
// No logic here: write-FSM encoding, build-mode selectors and statistics width.
package axis_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PKT     = 2'd1,
    DISCARD = 2'd2
  } wr_state_e;

  localparam int MODE_CUT_THROUGH = 0;
  localparam int MODE_STORE_FWD   = 1;

  localparam int DROP_CNT_W = 32;

endpackage

// File: rtl/axis_pkt_fifo_if.sv
// AXI-Stream beat bundle with master (driver) and slave (receiver) views.
// Plain wires only: no latency, tready is the sole backpressure signal.
interface axis_pkt_fifo_if #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 72
);

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tvalid;
  logic                  tready;

  modport master (
    output tdata, tkeep, tlast, tuser, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tlast, tuser, tvalid,
    output tready
  );

endinterface

// File: rtl/axis_fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle read latency).
// No backpressure; the read register only changes when rd_en is high, so it holds egress data.
module axis_fifo_sdp_ram #(
  parameter int WIDTH      = 145,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_dat,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Array is left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_dat <= '0;
    end else if (rd_en) begin
      rd_dat <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/axis_pkt_fifo.sv
// Single-clock AXI-Stream packet FIFO: store-and-forward or cut-through, bad/oversize frame drop.
// Egress 1 cycle after commit; s_axis.tready depends on FSM/full only, never on m_axis.tready.
module axis_pkt_fifo
  import axis_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 72,
  parameter int DEPTH      = 512,
  parameter int STORE_FWD  = MODE_STORE_FWD,
  parameter int DROP_BAD   = 1,
  parameter int ERR_BIT    = 0,
  parameter int AF_THRESH  = DEPTH - 16,
  parameter int AE_THRESH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  axis_pkt_fifo_if.slave          s_axis,
  axis_pkt_fifo_if.master         m_axis,
  output logic [$clog2(DEPTH):0]  level,
  output logic [$clog2(DEPTH):0]  pkt_count,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    drop_pulse,
  output logic [DROP_CNT_W-1:0]   drop_count,
  output logic                    overflow,
  input  logic                    clear_stats
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int PTR_W      = ADDR_WIDTH + 1;
  localparam int BEAT_W     = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;

  localparam bit SF      = (STORE_FWD == MODE_STORE_FWD);
  localparam bit CT      = (STORE_FWD == MODE_CUT_THROUGH);
  localparam bit DROP_EN = SF && (DROP_BAD != 0);

  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_LVL  = PTR_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] AE_LVL  = PTR_W'(AE_THRESH);
  localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

  wr_state_e        state, state_nxt;
  logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0] commit_ptr, commit_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr;

  logic rdy_en;
  logic full;
  logic wr_fire;
  logic wr_en;
  logic is_bad;
  logic inc_pkt;
  logic dec_pkt;
  logic drop_now;
  logic ovf_now;

  logic              rd_avail;
  logic              rd_load;
  logic              out_vld;
  logic              out_fire;
  logic [BEAT_W-1:0] wr_dat;
  logic [BEAT_W-1:0] rd_dat;

  // rdy_en keeps tready low until the first edge after reset release.
  assign full           = ((wr_ptr - rd_ptr) == DEPTH_P);
  assign s_axis.tready  = rdy_en && ((state == DISCARD) || !full);
  assign wr_fire        = s_axis.tvalid && s_axis.tready;
  assign is_bad         = DROP_EN && s_axis.tuser[ERR_BIT];
  assign wr_dat         = {s_axis.tdata, s_axis.tkeep, s_axis.tlast, s_axis.tuser};

  always_comb begin
    state_nxt      = state;
    wr_ptr_nxt     = wr_ptr;
    commit_ptr_nxt = commit_ptr;
    wr_en          = 1'b0;
    inc_pkt        = 1'b0;
    drop_now       = 1'b0;
    ovf_now        = 1'b0;
    case (state)
      IDLE, PKT: begin
        if (wr_fire) begin
          wr_en      = 1'b1;
          wr_ptr_nxt = wr_ptr + ONE_P;
          if (CT) begin
            commit_ptr_nxt = wr_ptr + ONE_P;
          end
          if (s_axis.tlast) begin
            state_nxt = IDLE;
            if (is_bad) begin
              wr_ptr_nxt = commit_ptr;
              drop_now   = 1'b1;
            end else begin
              commit_ptr_nxt = wr_ptr + ONE_P;
              inc_pkt        = 1'b1;
            end
          end else begin
            state_nxt = PKT;
          end
        end else if (SF && (state == PKT) && full && (commit_ptr == rd_ptr)) begin
          // Frame alone fills the memory and can never commit: give it up.
          state_nxt  = DISCARD;
          wr_ptr_nxt = commit_ptr;
          ovf_now    = 1'b1;
        end
      end
      DISCARD: begin
        if (wr_fire && s_axis.tlast) begin
          state_nxt = IDLE;
          drop_now  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_avail = (rd_ptr != commit_ptr);
  assign out_fire = out_vld && m_axis.tready;
  assign rd_load  = rd_avail && (!out_vld || m_axis.tready);
  assign dec_pkt  = out_fire && rd_dat[USER_WIDTH];

  axis_fifo_sdp_ram #(
    .WIDTH      (BEAT_W),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_dat  (wr_dat),
    .rd_en   (rd_load),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_dat  (rd_dat)
  );

  assign {m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tuser} = rd_dat;
  assign m_axis.tvalid = out_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      rdy_en     <= 1'b0;
      out_vld    <= 1'b0;
      pkt_count  <= '0;
      drop_pulse <= 1'b0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      commit_ptr <= commit_ptr_nxt;
      rdy_en     <= 1'b1;
      drop_pulse <= drop_now;

      if (rd_load) begin
        rd_ptr  <= rd_ptr + ONE_P;
        out_vld <= 1'b1;
      end else if (out_fire) begin
        out_vld <= 1'b0;
      end

      case ({inc_pkt, dec_pkt})
        2'b10:   pkt_count <= pkt_count + ONE_P;
        2'b01:   pkt_count <= pkt_count - ONE_P;
        default: pkt_count <= pkt_count;
      endcase

      // Clear has priority over a same-cycle drop or overflow event.
      if (clear_stats) begin
        drop_count <= '0;
      end else if (drop_now && (drop_count != '1)) begin
        drop_count <= drop_count + 1'b1;
      end

      if (clear_stats) begin
        overflow <= 1'b0;
      end else if (ovf_now) begin
        overflow <= 1'b1;
      end
    end
  end

  assign level        = wr_ptr - rd_ptr;
  assign almost_full  = (level >= AF_LVL);
  assign almost_empty = (level <= AE_LVL);

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: store-and-forward DUT against a frame-level scoreboard, plus a cut-through DUT.
// Frames are delivered unless flagged bad on tlast or longer than DEPTH; drops are counted by the model.
module tb_axis_pkt_fifo;

  localparam int DW    = 64;
  localparam int KW    = 8;
  localparam int UW    = 72;
  localparam int DEPTH = 16;
  localparam int PW    = 5;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic [UW-1:0] u;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  axis_pkt_fifo_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) s_axis (), m_axis (), s_ct (), m_ct ();

  logic [PW-1:0] level, pkt_count, level_ct, pkt_count_ct;
  logic          almost_full, almost_empty, drop_pulse, overflow, clear_stats;
  logic          almost_full_ct, almost_empty_ct, drop_pulse_ct, overflow_ct, clear_stats_ct;
  logic [31:0]   drop_count, drop_count_ct;

  axis_pkt_fifo #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .DEPTH(DEPTH), .STORE_FWD(1),
    .DROP_BAD(1), .ERR_BIT(0), .AF_THRESH(12), .AE_THRESH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_axis(s_axis), .m_axis(m_axis), .level(level),
    .pkt_count(pkt_count), .almost_full(almost_full), .almost_empty(almost_empty),
    .drop_pulse(drop_pulse), .drop_count(drop_count), .overflow(overflow), .clear_stats(clear_stats)
  );

  axis_pkt_fifo #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .DEPTH(DEPTH), .STORE_FWD(0),
    .DROP_BAD(1), .ERR_BIT(0), .AF_THRESH(12), .AE_THRESH(4)
  ) dut_ct (
    .clk(clk), .rst_n(rst_n), .s_axis(s_ct), .m_axis(m_ct), .level(level_ct),
    .pkt_count(pkt_count_ct), .almost_full(almost_full_ct), .almost_empty(almost_empty_ct),
    .drop_pulse(drop_pulse_ct), .drop_count(drop_count_ct), .overflow(overflow_ct),
    .clear_stats(clear_stats_ct)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state: expected egress beats, drop statistics.
  beat_t exp_q[$];
  int    hs_q[$];
  int    exp_drops = 0;
  int    exp_pulses = 0;
  bit    exp_ovf = 1'b0;
  int    pulses = 0;

  always @(negedge clk) begin
    beat_t b;
    if (rst_n) begin
      if (drop_pulse) pulses++;
      if (m_axis.tvalid && m_axis.tready) begin
        hs_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("eg_unexpected_beat", 64'(m_axis.tdata), 64'(0));
        end else begin
          b = exp_q.pop_front();
          chk("eg_data", m_axis.tdata, b.d);
          chk("eg_keep", 64'(m_axis.tkeep), 64'(b.k));
          chk("eg_last", 64'(m_axis.tlast), 64'(b.l));
          chk("eg_user_lo", m_axis.tuser[63:0], b.u[63:0]);
          chk("eg_user_hi", 64'(m_axis.tuser[71:64]), 64'(b.u[71:64]));
        end
      end
    end
  end

  task automatic send_beat(input beat_t b, input bit clr, input bit gaps);
    int t;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    s_axis.tdata  = b.d;
    s_axis.tkeep  = b.k;
    s_axis.tlast  = b.l;
    s_axis.tuser  = b.u;
    s_axis.tvalid = 1'b1;
    clear_stats   = clr;
    t = 0;
    forever begin
      @(negedge clk);
      if (s_axis.tready) break;
      t++;
      if (t > 1000) begin
        chk("src_timeout", 64'(0), 64'(1));
        break;
      end
    end
    @(posedge clk); #1;
    s_axis.tvalid = 1'b0;
    clear_stats   = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit err, input bit clr_last, input bit gaps);
    beat_t b;
    bit    drop;
    drop = err || (len > DEPTH);
    for (int i = 0; i < len; i++) begin
      b.d = {$urandom, $urandom};
      b.k = 8'($urandom);
      b.l = (i == len - 1);
      b.u = {8'($urandom), $urandom, $urandom};
      b.u[0] = b.l ? err : 1'($urandom);
      if (!drop) exp_q.push_back(b);
      send_beat(b, clr_last && b.l, gaps);
    end
    if (len > DEPTH) exp_ovf = 1'b1;
    if (drop) exp_pulses++;
    if (clr_last) begin
      exp_drops = 0;
      exp_ovf   = 1'b0;
    end else if (drop) begin
      exp_drops++;
    end
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || m_axis.tvalid) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 64'(exp_q.size()), 64'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  int  p0;
  bit  src_done;

  initial begin
    s_axis.tvalid = 0; s_axis.tdata = '0; s_axis.tkeep = '0; s_axis.tlast = 0; s_axis.tuser = '0;
    s_ct.tvalid   = 0; s_ct.tdata   = '0; s_ct.tkeep   = '0; s_ct.tlast   = 0; s_ct.tuser   = '0;
    m_axis.tready = 0; m_ct.tready = 1; clear_stats = 0; clear_stats_ct = 0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_s_tready", 64'(s_axis.tready), 64'(0));
    chk("rst_m_tvalid", 64'(m_axis.tvalid), 64'(0));
    chk("rst_m_tdata", m_axis.tdata, 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_pkt_count", 64'(pkt_count), 64'(0));
    chk("rst_drop_count", 64'(drop_count), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    chk("rst_drop_pulse", 64'(drop_pulse), 64'(0));
    chk("rst_almost_empty", 64'(almost_empty), 64'(1));
    chk("rst_almost_full", 64'(almost_full), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_before_edge", 64'(s_axis.tready), 64'(0));
    @(posedge clk); #1;
    chk("rdy_after_edge", 64'(s_axis.tready), 64'(1));

    // Cut-through: a bad-flagged single beat passes straight through
    s_ct.tdata = 64'hC0FF_EE00_1234_5678; s_ct.tkeep = 8'hFF; s_ct.tlast = 1'b1;
    s_ct.tuser = 72'hA5_0000_0000_0000_0001; s_ct.tvalid = 1'b1;
    @(negedge clk);
    chk("ct_s_tready", 64'(s_ct.tready), 64'(1));
    @(posedge clk); #1;
    s_ct.tvalid = 1'b0;
    @(negedge clk);
    chk("ct_tvalid_accept_cycle", 64'(m_ct.tvalid), 64'(0));
    @(negedge clk);
    chk("ct_tvalid_next_cycle", 64'(m_ct.tvalid), 64'(1));
    chk("ct_tdata", m_ct.tdata, 64'hC0FF_EE00_1234_5678);
    chk("ct_tuser_err", 64'(m_ct.tuser[0]), 64'(1));
    chk("ct_pkt_count", 64'(pkt_count_ct), 64'(1));
    @(negedge clk);
    chk("ct_tvalid_done", 64'(m_ct.tvalid), 64'(0));
    chk("ct_pkt_count_done", 64'(pkt_count_ct), 64'(0));
    chk("ct_drop_count", 64'(drop_count_ct), 64'(0));
    @(posedge clk); #1;

    // Store-and-forward 3-beat frame: latency and packet count
    m_axis.tready = 1'b1;
    send_frame(3, 0, 0, 0);
    @(negedge clk);
    chk("sf_tvalid_commit_cycle", 64'(m_axis.tvalid), 64'(0));
    chk("sf_pkt_count_1", 64'(pkt_count), 64'(1));
    chk("sf_level_3", 64'(level), 64'(3));
    @(negedge clk);
    chk("sf_tvalid_next_cycle", 64'(m_axis.tvalid), 64'(1));
    wait_drain("sf_drain");
    chk("sf_pkt_count_0", 64'(pkt_count), 64'(0));
    chk("sf_level_0", 64'(level), 64'(0));

    // Bad frame dropped with rollback
    p0 = pulses;
    send_frame(4, 1, 0, 0);
    repeat (3) @(negedge clk);
    chk("bad_pulses", 64'(pulses - p0), 64'(1));
    chk("bad_drop_count", 64'(drop_count), 64'(exp_drops));
    chk("bad_level", 64'(level), 64'(0));
    chk("bad_tvalid", 64'(m_axis.tvalid), 64'(0));
    @(posedge clk); #1;

    // Oversize frame with stalled egress goes to discard
    m_axis.tready = 1'b0;
    p0 = pulses;
    send_frame(20, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("ovs_overflow", 64'(overflow), 64'(exp_ovf));
    chk("ovs_drop_count", 64'(drop_count), 64'(exp_drops));
    chk("ovs_pulses", 64'(pulses - p0), 64'(1));
    chk("ovs_level", 64'(level), 64'(0));
    chk("ovs_pkt_count", 64'(pkt_count), 64'(0));
    @(posedge clk); #1;
    m_axis.tready = 1'b1;
    send_frame(2, 0, 0, 0);
    wait_drain("ovs_next_frame");

    // Fill with egress stalled, then release
    m_axis.tready = 1'b0;
    for (int f = 0; f < 4; f++) send_frame(4, 0, 0, 0);
    @(negedge clk);
    chk("fill_level_15", 64'(level), 64'(15));
    chk("fill_pkt_count", 64'(pkt_count), 64'(4));
    chk("fill_almost_full", 64'(almost_full), 64'(1));
    chk("fill_s_tready", 64'(s_axis.tready), 64'(1));
    chk("fill_m_tvalid", 64'(m_axis.tvalid), 64'(1));
    @(posedge clk); #1;
    fork
      send_frame(2, 0, 0, 0);
      begin
        int t;
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (level != 16 && t < 100);
        chk("full_level_16", 64'(level), 64'(16));
        chk("full_s_tready", 64'(s_axis.tready), 64'(0));
        chk("full_pkt_count", 64'(pkt_count), 64'(4));
        hs_q.delete();
        @(posedge clk); #1;
        m_axis.tready = 1'b1;
      end
    join
    wait_drain("full_drain");
    chk("b2b_count", 64'(hs_q.size()), 64'(18));
    if (hs_q.size() >= 16) chk("b2b_span", 64'(hs_q[15] - hs_q[0]), 64'(15));

    // Clear in the same cycle as a drop
    p0 = pulses;
    send_frame(3, 1, 1, 0);
    repeat (2) @(negedge clk);
    chk("clr_drop_count", 64'(drop_count), 64'(exp_drops));
    chk("clr_overflow", 64'(overflow), 64'(exp_ovf));
    chk("clr_pulses", 64'(pulses - p0), 64'(1));
    @(posedge clk); #1;

    // Randomized traffic with random egress stalls
    src_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 40; f++) send_frame($urandom_range(1, 10), ($urandom_range(0, 3) == 0), 0, 1);
        src_done = 1'b1;
      end
      begin
        while (!src_done) begin
          @(posedge clk); #1;
          m_axis.tready = 1'($urandom_range(0, 1));
        end
        m_axis.tready = 1'b1;
      end
    join
    wait_drain("rnd_drain");
    chk("rnd_drop_count", 64'(drop_count), 64'(exp_drops));
    chk("rnd_pulses", 64'(pulses), 64'(exp_pulses));
    chk("rnd_pkt_count", 64'(pkt_count), 64'(0));
    chk("rnd_level", 64'(level), 64'(0));
    chk("rnd_overflow", 64'(overflow), 64'(exp_ovf));
    chk("rnd_almost_empty", 64'(almost_empty), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
